// File: rtl/mxv_sequencer.sv
// mxv_sequencer: control sequencer for the 4-lane matrix-by-vector datapath.
// Steers the serial matrix load stream into four lane FIFOs (zero-padding
// lanes beyond N), then issues skewed systolic pops for one or two 4-column
// passes, steering the vector half, the feedback path and the result FIFO.
// Every output is a register; compute-phase outputs are derived from the
// next-state counters so they line up with the cycle the counters describe.
module mxv_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int MAX_N       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] Matrix_length,
  input  logic                   FIFOpush,
  output logic                   push1,
  output logic                   push2,
  output logic                   push3,
  output logic                   push4,
  output logic                   mux0_flag,
  output logic                   pop1,
  output logic                   pop2,
  output logic                   pop3,
  output logic                   pop4,
  output logic                   muxV_sel,
  output logic                   feedback_sel,
  output logic                   push_result,
  output logic                   pop_result,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // Counter width covers t = 0..MAX_N+3 and N itself.
  localparam int CW = $clog2(MAX_N + 5);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] n_r, n_s;
  logic [CW-1:0] r_r, r_s;
  logic [CW-1:0] t_r, t_s;
  logic [1:0]    l_r, l_s;
  logic          p_r, p_s;
  logic          two_pass_r, two_pass_s;
  logic          legal_s, real_slot_s;

  logic [3:0] push_s, push_r;
  logic [3:0] pop_s, pop_r;
  logic mux0_s, mux0_r, muxv_s, muxv_r, fb_s, fb_r;
  logic pres_s, pres_r, popres_s, popres_r;
  logic busy_s, busy_r, done_s, done_r, err_s, err_r;

  assign legal_s     = (Matrix_length >= WORD_LENGTH'(1)) &&
                       (Matrix_length <= WORD_LENGTH'(MAX_N));
  // Column c = 4p + l holds a real element only when c < N.
  assign real_slot_s = CW'({p_r, l_r}) < n_r;

  // Next-state sequencing: job acceptance, load slot walk, compute pass timing.
  always_comb begin
    state_s    = state_r;
    n_s        = n_r;
    two_pass_s = two_pass_r;
    p_s        = p_r;
    r_s        = r_r;
    l_s        = l_r;
    t_s        = t_r;
    push_s     = 4'b0000;
    mux0_s     = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (legal_s) begin
            n_s        = CW'(Matrix_length);
            two_pass_s = Matrix_length > WORD_LENGTH'(4);
            p_s        = 1'b0;
            r_s        = {CW{1'b0}};
            l_s        = 2'd0;
            t_s        = {CW{1'b0}};
            state_s    = S_LOAD;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        // Pad slots never wait; real slots wait for the source strobe.
        if (!real_slot_s || FIFOpush) begin
          push_s[l_r] = 1'b1;
          mux0_s      = !real_slot_s;
          if (l_r == 2'd3) begin
            l_s = 2'd0;
            if (r_r == n_r - CW'(1)) begin
              r_s = {CW{1'b0}};
              if (p_r == two_pass_r) begin
                state_s = S_COMPUTE;
                p_s     = 1'b0;
                t_s     = {CW{1'b0}};
              end else begin
                p_s = 1'b1;
              end
            end else begin
              r_s = r_r + CW'(1);
            end
          end else begin
            l_s = l_r + 2'd1;
          end
        end else begin
          state_s = S_LOAD;
        end
      end
      S_COMPUTE: begin
        if (t_r == n_r + CW'(3)) begin
          t_s = {CW{1'b0}};
          if (p_r != two_pass_r) begin
            p_s = 1'b1;
          end else begin
            p_s     = 1'b0;
            done_s  = 1'b1;
            state_s = S_IDLE;
          end
        end else begin
          t_s = t_r + CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Compute-phase strobes decoded from the upcoming pass/time counters.
  always_comb begin
    pop_s    = 4'b0000;
    muxv_s   = 1'b0;
    fb_s     = 1'b0;
    pres_s   = 1'b0;
    popres_s = 1'b0;
    busy_s   = (state_s == S_LOAD) || (state_s == S_COMPUTE);
    if (state_s == S_COMPUTE) begin
      // Lane k+1 streams rows 0..N-1 starting k cycles late (systolic skew).
      for (int i = 0; i < 4; i++) begin
        pop_s[i] = (t_s >= CW'(i)) && (t_s < n_r + CW'(i));
      end
      muxv_s   = p_s;
      fb_s     = p_s;
      // P4 result is registered, so it is valid one cycle after each pop4.
      pres_s   = (t_s >= CW'(4)) && (t_s <= n_r + CW'(3));
      popres_s = pop_s[3] && p_s;
    end else begin
      pop_s = 4'b0000;
    end
  end

  // State, counters and registered outputs; reset aborts any job at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      n_r        <= {CW{1'b0}};
      two_pass_r <= 1'b0;
      p_r        <= 1'b0;
      r_r        <= {CW{1'b0}};
      l_r        <= 2'd0;
      t_r        <= {CW{1'b0}};
      push_r     <= 4'b0000;
      pop_r      <= 4'b0000;
      mux0_r     <= 1'b0;
      muxv_r     <= 1'b0;
      fb_r       <= 1'b0;
      pres_r     <= 1'b0;
      popres_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      n_r        <= n_s;
      two_pass_r <= two_pass_s;
      p_r        <= p_s;
      r_r        <= r_s;
      l_r        <= l_s;
      t_r        <= t_s;
      push_r     <= push_s;
      pop_r      <= pop_s;
      mux0_r     <= mux0_s;
      muxv_r     <= muxv_s;
      fb_r       <= fb_s;
      pres_r     <= pres_s;
      popres_r   <= popres_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign push1        = push_r[0];
  assign push2        = push_r[1];
  assign push3        = push_r[2];
  assign push4        = push_r[3];
  assign mux0_flag    = mux0_r;
  assign pop1         = pop_r[0];
  assign pop2         = pop_r[1];
  assign pop3         = pop_r[2];
  assign pop4         = pop_r[3];
  assign muxV_sel     = muxv_r;
  assign feedback_sel = fb_r;
  assign push_result  = pres_r;
  assign pop_result   = popres_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_mxv_sequencer.sv
// tb_mxv_sequencer: randomized bench for mxv_sequencer. A transaction-level
// model (slot queue for loading, pass/time arithmetic for compute) predicts
// every output each cycle; outputs are sampled 1 time unit after posedge.
module tb_mxv_sequencer;

  logic       clk, reset, start, FIFOpush;
  logic [7:0] Matrix_length;
  logic push1, push2, push3, push4, mux0_flag, pop1, pop2, pop3, pop4;
  logic muxV_sel, feedback_sel, push_result, pop_result, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  localparam int M_IDLE    = 0;
  localparam int M_LOAD    = 1;
  localparam int M_COMPUTE = 2;

  // Model state: phase, compute cycle index, job size, pass count, slot list.
  int mode = M_IDLE;
  int k    = 0;
  int jn   = 0;
  int jp   = 0;
  int q[$];
  int pads_o, pres_o, popres_o, done_o;

  mxv_sequencer #(.WORD_LENGTH(8), .MAX_N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .Matrix_length(Matrix_length),
    .FIFOpush(FIFOpush),
    .push1(push1), .push2(push2), .push3(push3), .push4(push4),
    .mux0_flag(mux0_flag),
    .pop1(pop1), .pop2(pop2), .pop3(pop3), .pop4(pop4),
    .muxV_sel(muxV_sel), .feedback_sel(feedback_sel),
    .push_result(push_result), .pop_result(pop_result),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {16'd0, push4, push3, push2, push1, mux0_flag, pop4, pop3, pop2, pop1,
            muxV_sel, feedback_sel, push_result, pop_result, busy, done, err};
  endfunction

  // Advance the model across one clock edge and return the expected outputs after it.
  function automatic logic [31:0] model_step(input logic st, input logic [7:0] ml, input logic fp);
    int push_oh = 0, mux0 = 0, err_e = 0, done_e = 0, busy_e = 0;
    int pop_oh = 0, muxv = 0, fb = 0, pres = 0, popres = 0;
    int p, t;
    case (mode)
      M_IDLE: begin
        if (st) begin
          if (ml >= 8'd1 && ml <= 8'd8) begin
            jn = int'(ml);
            jp = (jn + 3) / 4;
            q.delete();
            for (int pp = 0; pp < jp; pp++)
              for (int rr = 0; rr < jn; rr++)
                for (int ll = 0; ll < 4; ll++)
                  q.push_back(ll + ((4 * pp + ll >= jn) ? 4 : 0));
            mode = M_LOAD;
          end else begin
            err_e = 1;
          end
        end
      end
      M_LOAD: begin
        if (q[0] >= 4 || fp) begin
          push_oh = 1 << (q[0] % 4);
          mux0    = q[0] / 4;
          void'(q.pop_front());
          if (q.size() == 0) begin
            mode = M_COMPUTE;
            k    = 0;
          end
        end
      end
      M_COMPUTE: begin
        k++;
        if (k == jp * (jn + 4)) begin
          mode   = M_IDLE;
          done_e = 1;
        end
      end
      default: ;
    endcase
    if (mode == M_COMPUTE) begin
      p = k / (jn + 4);
      t = k % (jn + 4);
      for (int i = 0; i < 4; i++)
        if (t >= i && t <= i - 1 + jn) pop_oh |= (1 << i);
      muxv   = p;
      fb     = p;
      pres   = (t >= 4 && t <= jn + 3) ? 1 : 0;
      popres = (p == 1 && ((pop_oh >> 3) & 1) == 1) ? 1 : 0;
    end
    busy_e = (mode != M_IDLE) ? 1 : 0;
    return 32'((push_oh << 12) | (mux0 << 11) | (pop_oh << 7) | (muxv << 6) | (fb << 5) |
               (pres << 4) | (popres << 3) | (busy_e << 2) | (done_e << 1) | err_e);
  endfunction

  task automatic cycle(input logic st, input logic [7:0] ml, input logic fp, input string tag);
    logic [31:0] e;
    start         = st;
    Matrix_length = ml;
    FIFOpush      = fp;
    e = model_step(st, ml, fp);
    @(posedge clk);
    #1;
    check_eq(tag, obs_vec(), e);
    if (mux0_flag)   pads_o++;
    if (push_result) pres_o++;
    if (pop_result)  popres_o++;
    if (done)        done_o++;
  endtask

  // fpm: 0 = strobe every cycle, 1 = every 3rd cycle, 2 = random. abort_k >= 0 stops at that compute cycle.
  task automatic run_job(input int n, input int fpm, input int abort_k);
    int cyc = 0;
    int passes = (n + 3) / 4;
    logic fp, st;
    logic [7:0] ml;
    pads_o = 0; pres_o = 0; popres_o = 0; done_o = 0;
    cycle(1'b1, 8'(n), 1'b0, "start");
    while (mode != M_IDLE && cyc < 400) begin
      if (abort_k >= 0 && mode == M_COMPUTE && k == abort_k) break;
      case (fpm)
        0:       fp = 1'b1;
        1:       fp = (cyc % 3 == 2);
        default: fp = 1'($urandom_range(0, 1));
      endcase
      st = (mode == M_COMPUTE) && ($urandom_range(0, 3) == 0);
      ml = 8'($urandom_range(1, 8));
      cycle(st, ml, fp, (mode == M_LOAD) ? "load" : "compute");
      cyc++;
    end
    if (cyc >= 400) check_eq("timeout", 32'(cyc), 32'(0));
    if (abort_k < 0) begin
      check_eq("pad_count",        32'(pads_o),   32'(4 * n * passes - n * n));
      check_eq("push_result_count", 32'(pres_o),  32'(n * passes));
      check_eq("pop_result_count", 32'(popres_o), 32'((passes == 2) ? n : 0));
      check_eq("done_count",       32'(done_o),   32'(1));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; FIFOpush = 1'b0; Matrix_length = 8'd0;
    #7;
    check_eq("reset_state", obs_vec(), 32'd0);
    #5 reset = 1'b0;
    cycle(1'b0, 8'd0, 1'b1, "idle");

    run_job(4, 0, -1);
    run_job(6, 0, -1);
    run_job(1, 0, -1);
    run_job(4, 1, -1);

    cycle(1'b1, 8'd0,   1'b0, "err_zero");
    cycle(1'b0, 8'd0,   1'b1, "idle_after_err");
    cycle(1'b1, 8'd9,   1'b0, "err_nine");
    cycle(1'b1, 8'd200, 1'b1, "err_big");
    cycle(1'b0, 8'd3,   1'b0, "idle_after_err2");

    run_job(5, 2, -1);

    // Abort an N=8 job in pass 1 (t=3) with an asynchronous reset.
    run_job(8, 2, 8 + 4 + 3);
    reset = 1'b1; start = 1'b0; FIFOpush = 1'b0;
    #1;
    check_eq("reset_mid_job", obs_vec(), 32'd0);
    mode = M_IDLE;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_job(2, 2, -1);

    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
